// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared encodings and width helpers for the FIFO controller
package fifo_pkg;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_ONE   = 2'd1,
    OUT_TWO   = 2'd2
  } out_state_e;

  // Extra pointer bit distinguishes full from empty when low bits match.
  localparam int PTR_WRAP_BITS = 1;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// rtl/fifo_out_stage.sv - 2-entry output register absorbing the memory read latency
module fifo_out_stage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [1:0]            out_cnt,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  m_valid
);

  out_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = OUT_EMPTY;
    end else begin
      unique case (state_q)
        OUT_EMPTY: begin
          if (wr_en) begin
            head_d  = wr_data;
            state_d = OUT_ONE;
          end
        end
        OUT_ONE: begin
          if (pop) begin
            if (wr_en) head_d = wr_data;
            else       state_d = OUT_EMPTY;
          end else if (wr_en) begin
            tail_d  = wr_data;
            state_d = OUT_TWO;
          end
        end
        OUT_TWO: begin
          // Second entry slides into the head on a pop.
          if (pop) begin
            head_d = tail_q;
            if (wr_en) tail_d = wr_data;
            else       state_d = OUT_ONE;
          end
        end
        default: state_d = OUT_EMPTY;
      endcase
    end
  end

  assign out_cnt   = state_q;
  assign head_data = head_q;
  assign m_valid   = (state_q != OUT_EMPTY);

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, fetch and flow control for a registered-read FIFO memory
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int ADDR_W      = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_W+1:0]     count,
  output logic                  almost_full,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PTR_W = ADDR_W + PTR_WRAP_BITS;
  localparam int CNT_W = ADDR_W + 2;

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W-1:0] mem_count, mem_count_d;
  logic             inflight_q, af_q, af_d;
  logic             full, push, pop, fetch;
  logic [1:0]       out_cnt;
  logic [2:0]       stage_occ, stage_need;

  assign mem_count  = wptr_q - rptr_q;
  assign full       = (mem_count == PTR_W'(DEPTH));
  assign s_ready    = !full;
  assign push       = s_valid && s_ready && !flush && !rst;
  assign pop        = m_valid && m_ready && !flush;
  assign stage_occ  = {1'b0, out_cnt} + {2'b0, inflight_q};
  assign stage_need = stage_occ - {2'b0, pop};
  // Only words committed on an earlier edge are fetched, so read-first never matters.
  assign fetch      = !flush && (mem_count != '0) && (stage_need < 3'd2);

  always_comb begin
    wptr_d      = wptr_q + PTR_W'(push);
    rptr_d      = rptr_q + PTR_W'(fetch);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
    mem_count_d = wptr_d - rptr_d;
    af_d        = (int'(mem_count_d) >= AFULL_THRESH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= fetch;
      af_q       <= af_d;
    end
  end

  fifo_out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (inflight_q),
    .wr_data   (mem_rdata),
    .pop       (pop),
    .out_cnt   (out_cnt),
    .head_data (m_data),
    .m_valid   (m_valid)
  );

  assign mem_we      = push;
  assign mem_waddr   = wptr_q[ADDR_W-1:0];
  assign mem_wdata   = s_data;
  assign mem_raddr   = rptr_q[ADDR_W-1:0];
  assign almost_full = af_q;
  assign count       = CNT_W'(mem_count) + CNT_W'(out_cnt) + CNT_W'(inflight_q);

  a_stage_bound: assert property (@(posedge clk) disable iff (rst) stage_occ <= 3'd2);

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - randomized queue-model bench for fifo_ctrl
module tb_fifo_ctrl;

  localparam int DW     = 16;
  localparam int DEPTH  = 16;
  localparam int THRESH = DEPTH - 2;
  localparam int AW     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [AW+1:0] count;
  logic          almost_full;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(THRESH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .almost_full (almost_full),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata)
  );

  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    mem_rdata <= mem[mem_raddr];
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] sq[$];
  int            infl_v = 0;
  logic [DW-1:0] infl_d = '0;
  int            af_m = 0;
  int            wcnt = 0;
  int            rcnt = 0;
  int            accepted = 0;
  int            popped = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sq.delete();
    infl_v = 0;
    af_m   = 0;
    wcnt   = 0;
    rcnt   = 0;
  endtask

  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
    int  fetch_m;
    logic exp_sr, exp_mv, push_m, pop_m;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    @(negedge clk);
    exp_sr = (mq.size() < DEPTH);
    exp_mv = (sq.size() != 0);
    push_m = sv && exp_sr && !fl;
    pop_m  = mr && exp_mv && !fl;
    fetch_m = (!fl && mq.size() > 0 && (sq.size() + infl_v - int'(pop_m)) < 2) ? 1 : 0;
    check("s_ready", 32'(s_ready), 32'(exp_sr));
    check("m_valid", 32'(m_valid), 32'(exp_mv));
    if (exp_mv) check("m_data", 32'(m_data), 32'(sq[0]));
    check("count", 32'(count), 32'(mq.size() + sq.size() + infl_v));
    check("almost_full", 32'(almost_full), 32'(af_m));
    check("mem_we", 32'(mem_we), 32'(push_m));
    if (push_m) begin
      check("mem_waddr", 32'(mem_waddr), 32'(wcnt % DEPTH));
      check("mem_wdata", 32'(mem_wdata), 32'(sd));
    end
    if (fetch_m != 0) check("mem_raddr", 32'(mem_raddr), 32'(rcnt % DEPTH));
    if (fl) begin
      model_clear();
    end else begin
      if (pop_m) begin
        void'(sq.pop_front());
        popped++;
      end
      if (infl_v != 0) sq.push_back(infl_d);
      infl_v = fetch_m;
      if (fetch_m != 0) begin
        infl_d = mq.pop_front();
        rcnt++;
      end
      if (push_m) begin
        mq.push_back(sd);
        wcnt++;
        accepted++;
      end
      af_m = (mq.size() >= THRESH) ? 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() + sq.size() + infl_v) != 0 && n < 60) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_done", 32'(count), 32'd0);
  endtask

  task automatic fill_and_pop_one();
    for (int i = 0; i < 20; i++) step(1'b1, DW'(16'h2000 + i), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd18);
    check("full_s_ready", 32'(s_ready), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int p0, n, seen;
    #2;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word latency: m_valid must rise three cycles after the push.
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check("lat_count", 32'(count), 32'd1);
      check("lat_m_valid", 32'(m_valid), (i >= 3) ? 32'd1 : 32'd0);
      step(1'b0, '0, 1'b0, 1'b0);
    end
    check("lat_m_data", 32'(m_data), 32'h1111);
    drain();

    fill_and_pop_one();
    check("refill_s_ready", 32'(s_ready), 32'd1);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    drain();

    // Streaming: 100 words with both sides always ready.
    p0 = popped;
    for (int i = 0; i < 103; i++) step(i < 100, DW'(i), 1'b1, 1'b0);
    check("stream_pops", 32'(popped - p0), 32'd100);
    drain();

    // Random traffic with 50% consumer backpressure.
    p0 = accepted;
    n = 0;
    while (accepted - p0 < 1000 && n < 6000) begin
      step(($urandom % 4) != 0, DW'($urandom), ($urandom % 2) == 1, 1'b0);
      n++;
    end
    check("random_budget", 32'(n < 6000), 32'd1);
    drain();

    // Flush with a fetch in flight.
    fill_and_pop_one();
    step(1'b0, '0, 1'b0, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_m_valid", 32'(m_valid), 32'd0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 6 && seen == 0; i++) begin
      if (m_valid) seen = 1;
      else step(1'b0, '0, 1'b0, 1'b0);
    end
    check("flush_beef_valid", 32'(m_valid), 32'd1);
    check("flush_beef_data", 32'(m_data), 32'hBEEF);
    drain();

    // Same again, interrupted by async reset.
    fill_and_pop_one();
    rst = 1'b1;
    #2;
    check("arst_count", 32'(count), 32'd0);
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_s_ready", 32'(s_ready), 32'd1);
    check("arst_mem_we", 32'(mem_we), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 6 && seen == 0; i++) begin
      if (m_valid) seen = 1;
      else step(1'b0, '0, 1'b0, 1'b0);
    end
    check("arst_beef_valid", 32'(m_valid), 32'd1);
    check("arst_beef_data", 32'(m_data), 32'hBEEF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
